simple_cpu_multicycle: RTL
==========================

// Module: simple_cpu_multicycle
// PURPOSE
//  Parametrised multi-cycle successor of the single-step accumulator datapath.
//  Fetches instructions from an external program memory using an internal PC.
//  Runs a FETCH/DECODE/EXECUTE FSM over a 2**REG_ADDR_WIDTH register file.
//  Adds conditional branches on C/Z flags, HALT, and a registered output port
//  with a valid strobe that feeds the BCD display block.
// PARAMETERS
//  DATA_WIDTH      8   datapath, register, switch-extend and output width
//  REG_ADDR_WIDTH  2   register select width; NUM_REGS = 2**REG_ADDR_WIDTH
//  PC_WIDTH        6   program counter width; program space 2**PC_WIDTH words
//  SWITCH_WIDTH    6   external switch width, zero-extended (<= DATA_WIDTH)
//  INSTR_WIDTH     4+2*REG_ADDR_WIDTH+DATA_WIDTH (16); derived, do not override
// PORTS
//  Clk          in   1             single clock, rising edge
//  Rstn         in   1             synchronous, active-low reset
//  Run          in   1             level; 0 = park at next FETCH boundary
//  ImemAddr     out  PC_WIDTH      = PC (combinational from PC register)
//  ImemData     in   INSTR_WIDTH   instr word, valid same cycle as ImemAddr
//  ExternalSwitch in SWITCH_WIDTH  operand for IN
//  OutData      out  DATA_WIDTH    output port register
//  OutValid     out  1             1-cycle pulse on each OUT write
//  LED          out  DATA_WIDTH    last ALU result, registered
//  CF, ZF       out  1             carry/borrow and zero flags
//  Halted       out  1             1 once HALT has executed
// BEHAVIOUR
//  Reset: Rstn=0 at a rising edge -> PC, IR, all regs, OutData, LED, CF, ZF = 0;
//   OutValid=0, Halted=0, state=FETCH. Applies in any state; an in-flight
//   instruction is abandoned with no register, flag or port write.
//  IR = {op[3:0], rd, rs, imm[DATA_WIDTH-1:0]} MSB first.
//  FSM: FETCH -(Run)-> DECODE -> EXECUTE -> FETCH; FETCH with Run=0 holds.
//   EXECUTE of HALT -> HALTED; leaves HALTED only via reset. 3 cycles/instr.
//  FETCH: IR <= ImemData. DECODE: A <= R[rd], B <= R[rs]. EXECUTE: write-back,
//   flags, PC update, all on the edge leaving EXECUTE.
//  Run is sampled only in FETCH; Run=0 mid-instruction completes it.
//  PC <= PC+1 mod 2**PC_WIDTH unless a branch is taken; then PC <= imm[PC_WIDTH-1:0].
//  Opcodes: 0 NOP | 1 MOV rd<=rs | 2 LDI rd<=imm | 3 IN rd<=zext(switch)
//   4 ADD rd<=rd+rs | 5 SUB rd<=rd-rs | 6 AND | 7 OR | 8 XOR
//   9 INC rd<=rd+1 | A SHL rd<=rd<<1 | B OUT OutData<=R[rs] | C JMP
//   D JC (if CF) | E JZ (if ZF) | F HALT.
//  Arithmetic is DATA_WIDTH+1 wide. CF = bit DATA_WIDTH for ADD/INC;
//   CF = borrow (rd<rs unsigned) for SUB; CF = shifted-out MSB for SHL.
//  AND/OR/XOR: CF<=0. All ops 4-A: ZF<=(result==0), LED<=result.
//  Opcodes 0-3 and B-F leave CF, ZF and LED unchanged.
//  rd==rs is legal: operands come from the DECODE latches, e.g. SUB r,r -> 0, ZF=1.
//  OutValid is high only in the cycle after OUT's EXECUTE; OutData holds until
//   the next OUT. JC/JZ use flags as they stand entering EXECUTE.
// TESTING
//  T1 Rstn low 2 cycles -> all outputs 0, ImemAddr=0; Run=1 ->
//   program LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT -> OutValid high only
//   in cycle 12 after release with OutData=8, LED=8, CF=0, ZF=0, Halted=1 at 15.
//  T2 LDI r0,FF; INC r0; JC 10 -> R0=0, CF=1, ZF=1, next ImemAddr=10.
//  T3 LDI r0,3; LDI r1,5; SUB r0,r1 -> R0=FE, CF=1, ZF=0; JZ not taken.
//  T4 Drop Run during DECODE -> instr completes, FSM parks in FETCH with
//   ImemAddr stable for 10 cycles; raise Run -> resumes with the next instr.
//  T5 NOPs at 3E, 3F -> ImemAddr wraps 3F->00, no flag change.
//  T6 Rstn low in EXECUTE of ADD r0,r1 -> R0 not written, CF=ZF=0, PC=0 next cycle.

Source files
------------

// File: rtl/simple_cpu_multicycle.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXECUTE over a small register file,
// with C/Z conditional branches, HALT and a strobed output port.
module simple_cpu_multicycle #(
   parameter int  DATA_WIDTH     = 8,
   parameter int  REG_ADDR_WIDTH = 2,
   parameter int  PC_WIDTH       = 6,
   parameter int  SWITCH_WIDTH   = 6,
   localparam int INSTR_WIDTH    = 4 + 2*REG_ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                    Clk,
   input  logic                    Rstn,
   input  logic                    Run,
   output logic [PC_WIDTH-1:0]     ImemAddr,
   input  logic [INSTR_WIDTH-1:0]  ImemData,
   input  logic [SWITCH_WIDTH-1:0] ExternalSwitch,
   output logic [DATA_WIDTH-1:0]   OutData,
   output logic                    OutValid,
   output logic [DATA_WIDTH-1:0]   LED,
   output logic                    CF,
   output logic                    ZF,
   output logic                    Halted,
   output logic [1:0]              DbgState
);

   localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_LDI  = 4'h2;
   localparam logic [3:0] OP_IN   = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_INC  = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hA;
   localparam logic [3:0] OP_OUT  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_JC   = 4'hD;
   localparam logic [3:0] OP_JZ   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [PC_WIDTH-1:0]       r_pc;
   logic [INSTR_WIDTH-1:0]    r_ir;
   logic [DATA_WIDTH-1:0]     r_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0]     r_a;
   logic [DATA_WIDTH-1:0]     r_b;
   logic [DATA_WIDTH-1:0]     r_out_data;
   logic                      r_out_valid;
   logic [DATA_WIDTH-1:0]     r_led;
   logic                      r_cf;
   logic                      r_zf;

   logic [3:0]                w_op;
   logic [REG_ADDR_WIDTH-1:0] w_rd;
   logic [REG_ADDR_WIDTH-1:0] w_rs;
   logic [DATA_WIDTH-1:0]     w_imm;
   logic [DATA_WIDTH:0]       w_sum;
   logic [DATA_WIDTH-1:0]     w_wr_data;
   logic                      w_wr_en;
   logic                      w_flag_en;
   logic                      w_cf_new;
   logic                      w_out_en;
   logic                      w_br_taken;
   logic [PC_WIDTH-1:0]       w_pc_next;

   assign w_op  = r_ir[INSTR_WIDTH-1 -: 4];
   assign w_rd  = r_ir[DATA_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
   assign w_rs  = r_ir[DATA_WIDTH +: REG_ADDR_WIDTH];
   assign w_imm = r_ir[DATA_WIDTH-1:0];

   // Execute stage works only on the DECODE latches, so rd==rs needs no special case.
   always_comb begin
      w_sum      = '0;
      w_wr_data  = r_a;
      w_wr_en    = 1'b0;
      w_flag_en  = 1'b0;
      w_cf_new   = r_cf;
      w_out_en   = 1'b0;
      w_br_taken = 1'b0;
      case (w_op)
         OP_MOV: begin w_wr_en = 1'b1; w_wr_data = r_b; end
         OP_LDI: begin w_wr_en = 1'b1; w_wr_data = w_imm; end
         OP_IN:  begin w_wr_en = 1'b1; w_wr_data = DATA_WIDTH'(ExternalSwitch); end
         OP_ADD: begin
            w_sum    = {1'b0, r_a} + {1'b0, r_b};
            w_cf_new = w_sum[DATA_WIDTH];
         end
         OP_SUB: begin
            w_sum    = {1'b0, r_a} - {1'b0, r_b};
            w_cf_new = w_sum[DATA_WIDTH];
         end
         OP_AND: begin w_sum = {1'b0, r_a & r_b}; w_cf_new = 1'b0; end
         OP_OR:  begin w_sum = {1'b0, r_a | r_b}; w_cf_new = 1'b0; end
         OP_XOR: begin w_sum = {1'b0, r_a ^ r_b}; w_cf_new = 1'b0; end
         OP_INC: begin
            w_sum    = {1'b0, r_a} + (DATA_WIDTH+1)'(1);
            w_cf_new = w_sum[DATA_WIDTH];
         end
         OP_SHL: begin
            w_sum    = {r_a, 1'b0};
            w_cf_new = w_sum[DATA_WIDTH];
         end
         OP_OUT: w_out_en   = 1'b1;
         OP_JMP: w_br_taken = 1'b1;
         OP_JC:  w_br_taken = r_cf;
         OP_JZ:  w_br_taken = r_zf;
         default: ;
      endcase
      if ((w_op >= OP_ADD) && (w_op <= OP_SHL)) begin
         w_wr_en   = 1'b1;
         w_flag_en = 1'b1;
         w_wr_data = w_sum[DATA_WIDTH-1:0];
      end
   end

   assign w_pc_next = w_br_taken ? w_imm[PC_WIDTH-1:0] : r_pc + PC_WIDTH'(1);

   always_ff @(posedge Clk) begin
      if (!Rstn) r_state <= ST_FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_FETCH:   if (Run) w_next_state = ST_DECODE;
         ST_DECODE:  w_next_state = ST_EXECUTE;
         ST_EXECUTE: w_next_state = (w_op == OP_HALT) ? ST_HALTED : ST_FETCH;
         ST_HALTED:  w_next_state = ST_HALTED;
         default:    w_next_state = ST_FETCH;
      endcase
   end

   // Reset wins over every stage, so an in-flight instruction never writes back.
   always_ff @(posedge Clk) begin
      if (!Rstn) begin
         r_pc        <= '0;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_led       <= '0;
         r_cf        <= 1'b0;
         r_zf        <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_FETCH: if (Run) r_ir <= ImemData;
            ST_DECODE: begin
               r_a <= r_regs[w_rd];
               r_b <= r_regs[w_rs];
            end
            ST_EXECUTE: begin
               if (w_wr_en) r_regs[w_rd] <= w_wr_data;
               if (w_flag_en) begin
                  r_cf  <= w_cf_new;
                  r_zf  <= (w_wr_data == '0);
                  r_led <= w_wr_data;
               end
               if (w_out_en) begin
                  r_out_data  <= r_b;
                  r_out_valid <= 1'b1;
               end
               r_pc <= w_pc_next;
            end
            default: ;
         endcase
      end
   end

   assign ImemAddr = r_pc;
   assign OutData  = r_out_data;
   assign OutValid = r_out_valid;
   assign LED      = r_led;
   assign CF       = r_cf;
   assign ZF       = r_zf;
   assign Halted   = (r_state == ST_HALTED);
   assign DbgState = r_state;

endmodule
